i2c_txn_sequencer: RTL and testbench



---
 rtl/i2c_txn_sequencer_pkg.sv | 47 ++++
 rtl/i2c_txn_watchdog.sv | 39 +++
 rtl/i2c_txn_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_txn_sequencer_pkg.sv
// ============================================================================
// Module      : i2c_txn_pkg
// Description : Shared encodings for the I2C transaction sequencer: byte
//               engine command codes, FSM state codes and command-word fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_txn_pkg;

  // Byte-engine command codes
  localparam logic [1:0] BCMD_START = 2'b00;
  localparam logic [1:0] BCMD_WRITE = 2'b01;
  localparam logic [1:0] BCMD_READ  = 2'b10;
  localparam logic [1:0] BCMD_STOP  = 2'b11;

  // Sequencer FSM states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  // Command-word field layout
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 7;
  localparam int RNW_BIT  = 7;
  localparam int LEN_LSB  = 8;
  localparam int LEN_W    = 2;

  // Transaction fields captured when a command is accepted
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rnw;
    logic [2:0]        len;   // 1..4 bytes
  } txn_cfg_t;

  // True for the states that present a byte command to the engine
  function automatic logic is_cmd_state(input logic [2:0] s);
    return (s == S_START) || (s == S_ADDR) || (s == S_DATA) || (s == S_STOP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_txn_watchdog.sv
// ============================================================================
// Module      : i2c_txn_watchdog
// Description : Counts cycles spent waiting for a byte-engine response and
//               flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
//               Used only when I2C_TXN_SEQUENCER_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_txn_watchdog #(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_wait,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Count waiting cycles; any non-wait cycle rearms the counter so each
  // wait period starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (!in_wait) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = in_wait && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
// ============================================================================
// Module      : i2c_txn_sequencer
// Description : Turns a CSR command/write-data pair into a START, address,
//               1..4 data bytes, STOP sequence on the byte-engine interface,
//               packs read bytes into rd_data and drives CSR status flags.
//               Optional macro I2C_TXN_SEQUENCER_TIMEOUT_EN adds a per-byte
//               response watchdog and a sticky timeout output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_txn_sequencer
  import i2c_txn_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_word,
  input  logic [31:0] wr_word,
  input  logic        cmd_valid,
  output logic        byte_cmd_valid,
  input  logic        byte_cmd_ready,
  output logic [1:0]  byte_cmd,
  output logic [7:0]  byte_tx,
  output logic        byte_nack,
  input  logic        byte_rsp_valid,
  input  logic        byte_rsp_ack,
  input  logic [7:0]  byte_rx,
  output logic [31:0] rd_data,
  output logic        status_busy,
  output logic        status_ack_err,
  output logic        status_done,
  output logic        status_data_ready
`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  logic [2:0]  r_state;
  logic [2:0]  r_ret;       // command state whose response WAIT expects
  txn_cfg_t    r_cfg;
  logic [31:0] r_wr;
  logic [31:0] r_rd;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_ack_err;
  logic        r_done;
  logic        r_drdy;
  logic        w_timeout_hit;
  logic [7:0]  w_wr_byte;
  logic        w_last_byte;
  logic        w_unused;

  assign w_wr_byte   = r_wr[{r_cnt[1:0], 3'b000} +: 8];
  assign w_last_byte = (r_cnt == (r_cfg.len - 3'd1));

`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
  logic r_timeout;

  i2c_txn_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .in_wait (r_state == S_WAIT),
    .expired (w_timeout_hit)
  );

  assign timeout  = r_timeout;
  assign w_unused = ^{cmd_word[31:LEN_LSB+LEN_W]};
`else
  assign w_timeout_hit = 1'b0;
  assign w_unused      = ^{cmd_word[31:LEN_LSB+LEN_W], 32'(TIMEOUT_CYCLES)};
`endif

  // Transaction FSM, latched command fields, read buffer and sticky status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ret     <= S_IDLE;
      r_cfg     <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_ack_err <= 1'b0;
      r_done    <= 1'b0;
      r_drdy    <= 1'b0;
`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_cfg.addr <= cmd_word[ADDR_LSB +: ADDR_W];
            r_cfg.rnw  <= cmd_word[RNW_BIT];
            r_cfg.len  <= {1'b0, cmd_word[LEN_LSB +: LEN_W]} + 3'd1;
            r_wr       <= wr_word;
            r_cnt      <= '0;
            r_ack_err  <= 1'b0;
            r_done     <= 1'b0;
            r_drdy     <= 1'b0;
            r_busy     <= 1'b1;
`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
            r_timeout  <= 1'b0;
`endif
            // A write leaves the last read result in place
            if (cmd_word[RNW_BIT]) begin
              r_rd <= '0;
            end
            r_state <= S_START;
          end
        end

        S_START, S_ADDR, S_DATA, S_STOP: begin
          if (byte_cmd_ready) begin
            r_ret   <= r_state;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (byte_rsp_valid) begin
            case (r_ret)
              S_START: r_state <= S_ADDR;
              S_ADDR: begin
                if (byte_rsp_ack) begin
                  r_state <= S_DATA;
                end else begin
                  r_ack_err <= 1'b1;
                  r_state   <= S_STOP;
                end
              end
              S_DATA: begin
                if (r_cfg.rnw) begin
                  r_rd[{r_cnt[1:0], 3'b000} +: 8] <= byte_rx;
                end
                r_cnt <= r_cnt + 3'd1;
                if (!r_cfg.rnw && !byte_rsp_ack) begin
                  r_ack_err <= 1'b1;
                  r_state   <= S_STOP;
                end else if (w_last_byte) begin
                  r_state <= S_STOP;
                end else begin
                  r_state <= S_DATA;
                end
              end
              default: r_state <= S_FIN;
            endcase
          end else if (w_timeout_hit) begin
            // Engine went silent: abandon the transaction without a STOP
            r_ack_err <= 1'b1;
`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
            r_timeout <= 1'b1;
`endif
            r_state   <= S_FIN;
          end
        end

        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_drdy  <= r_cfg.rnw & ~r_ack_err;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte command payload is a pure function of state so it stays stable
  // while the engine back-pressures and vanishes at once on reset
  always_comb begin
    byte_cmd_valid = is_cmd_state(r_state);
    byte_cmd       = BCMD_START;
    byte_tx        = 8'h00;
    byte_nack      = 1'b0;
    case (r_state)
      S_ADDR: begin
        byte_cmd = BCMD_WRITE;
        byte_tx  = {r_cfg.addr, r_cfg.rnw};
      end
      S_DATA: begin
        if (r_cfg.rnw) begin
          byte_cmd  = BCMD_READ;
          byte_nack = w_last_byte;
        end else begin
          byte_cmd = BCMD_WRITE;
          byte_tx  = w_wr_byte;
        end
      end
      S_STOP:  byte_cmd = BCMD_STOP;
      default: ;
    endcase
  end

  assign rd_data           = r_rd;
  assign status_busy       = r_busy;
  assign status_ack_err    = r_ack_err;
  assign status_done       = r_done;
  assign status_data_ready = r_drdy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_sequencer.sv
// ============================================================================
// Module      : tb_i2c_txn_sequencer
// Description : Self-checking bench for i2c_txn_sequencer with a byte-engine
//               responder, a transaction-level expected-command model and
//               directed scenarios. Timeout scenario needs
//               I2C_TXN_SEQUENCER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_txn_sequencer;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cmd_word;
  logic [31:0] wr_word;
  logic        cmd_valid;
  logic        byte_cmd_valid;
  logic        byte_cmd_ready;
  logic [1:0]  byte_cmd;
  logic [7:0]  byte_tx;
  logic        byte_nack;
  logic        byte_rsp_valid;
  logic        byte_rsp_ack;
  logic [7:0]  byte_rx;
  logic [31:0] rd_data;
  logic        status_busy;
  logic        status_ack_err;
  logic        status_done;
  logic        status_data_ready;
`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  i2c_txn_sequencer #(
    .CLK_FREQ       (100_000_000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_word          (cmd_word),
    .wr_word           (wr_word),
    .cmd_valid         (cmd_valid),
    .byte_cmd_valid    (byte_cmd_valid),
    .byte_cmd_ready    (byte_cmd_ready),
    .byte_cmd          (byte_cmd),
    .byte_tx           (byte_tx),
    .byte_nack         (byte_nack),
    .byte_rsp_valid    (byte_rsp_valid),
    .byte_rsp_ack      (byte_rsp_ack),
    .byte_rx           (byte_rx),
    .rd_data           (rd_data),
    .status_busy       (status_busy),
    .status_ack_err    (status_ack_err),
    .status_done       (status_done),
    .status_data_ready (status_data_ready)
`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
    ,
    .timeout           (timeout)
`endif
  );

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] tx;
    logic       nack;
  } bc_t;

  bc_t         exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Model results for the current transaction
  logic [31:0] m_rd = 32'h0;
  bit          m_err;
  bit          m_drdy;

  // Engine configuration and observation
  int          eng_delay   = 1;
  int          silent_from = 99;
  int          stall       = 0;
  logic [7:0]  ack_mask    = 8'hFF;
  logic [7:0]  rx_bytes [4];
  int          hs_count    = 0;
  int          rd_idx      = 0;
  bit          pend        = 0;
  int          timer       = 0;
  logic        p_ack;
  logic [7:0]  p_rx;
  logic [1:0]  act_cmd  [16];
  logic [7:0]  act_tx   [16];
  logic        act_nack [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected engine commands and end-of-transaction status from the rules
  task automatic model_txn(input logic [31:0] cw, input logic [31:0] ww);
    int len = int'(cw[9:8]) + 1;
    bit rnw = cw[7];
    bit err = 0;
    exp_q.push_back(bc_t'{C_START, 8'h00, 1'b0});
    exp_q.push_back(bc_t'{C_WRITE, {cw[6:0], rnw}, 1'b0});
    if (!ack_mask[1]) begin
      err = 1;
    end else begin
      for (int i = 0; i < len; i++) begin
        if (rnw) begin
          exp_q.push_back(bc_t'{C_READ, 8'h00, (i == len - 1)});
        end else begin
          exp_q.push_back(bc_t'{C_WRITE, ww[8*i +: 8], 1'b0});
          if (!ack_mask[2+i]) begin
            err = 1;
            break;
          end
        end
      end
    end
    exp_q.push_back(bc_t'{C_STOP, 8'h00, 1'b0});
    if (rnw) begin
      m_rd = 32'h0;
      if (!err) begin
        for (int i = 0; i < len; i++) m_rd[8*i +: 8] = rx_bytes[i];
      end
    end
    m_err  = err;
    m_drdy = rnw && !err;
  endtask

  // Byte-engine responder: handshake capture, delayed response, backpressure
  initial begin : engine
    bit         hs;
    logic [1:0] c_cmd;
    int         idx;
    byte_cmd_ready = 1'b1;
    byte_rsp_valid = 1'b0;
    byte_rsp_ack   = 1'b0;
    byte_rx        = 8'h00;
    forever begin
      @(negedge clk);
      hs    = reset_n && byte_cmd_valid && byte_cmd_ready;
      c_cmd = byte_cmd;
      if (hs && hs_count < 16) begin
        act_cmd[hs_count]  = byte_cmd;
        act_tx[hs_count]   = byte_tx;
        act_nack[hs_count] = byte_nack;
      end
      @(posedge clk);
      #1;
      byte_rsp_valid = 1'b0;
      if (hs) begin
        idx = hs_count;
        hs_count++;
        p_ack = (idx < 8) ? ack_mask[idx[2:0]] : 1'b1;
        p_rx  = 8'h00;
        if (c_cmd == C_READ) begin
          p_rx = rx_bytes[rd_idx[1:0]];
          rd_idx++;
        end
        if (idx < silent_from) begin
          pend  = 1;
          timer = eng_delay;
        end
      end
      if (pend) begin
        if (timer == 0) begin
          byte_rsp_valid = 1'b1;
          byte_rsp_ack   = p_ack;
          byte_rx        = p_rx;
          pend           = 0;
        end else begin
          timer--;
        end
      end
      if (stall > 0 && byte_cmd_valid) begin
        byte_cmd_ready = 1'b0;
        stall--;
      end else begin
        byte_cmd_ready = 1'b1;
      end
    end
  end

  // Every cycle a command is offered it must match the model's next entry
  initial begin : compare
    bc_t e;
    forever begin
      @(negedge clk);
      if (reset_n && byte_cmd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd actual=%0d required=none t=%0t", byte_cmd, $time);
        end else begin
          e = exp_q[0];
          check("byte_cmd", 32'(byte_cmd), 32'(e.cmd));
          if (e.cmd == C_WRITE) check("byte_tx", 32'(byte_tx), 32'(e.tx));
          if (e.cmd == C_READ)  check("byte_nack", 32'(byte_nack), 32'(e.nack));
          check("busy_during_cmd", 32'(status_busy), 32'h1);
          if (byte_cmd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_txn(input logic [31:0] cw, input logic [31:0] ww);
    model_txn(cw, ww);
    hs_count = 0;
    rd_idx   = 0;
    @(posedge clk);
    #1;
    cmd_word  = cw;
    wr_word   = ww;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_word  = ~cw;
    wr_word   = ~ww;
    check("busy_after_accept", 32'(status_busy), 32'h1);
    check("done_cleared", 32'(status_done), 32'h0);
    check("ack_err_cleared", 32'(status_ack_err), 32'h0);
    check("data_ready_cleared", 32'(status_data_ready), 32'h0);
  endtask

  task automatic finish_txn();
    int n = 0;
    while (!status_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!status_done) begin
      checks++;
      failures++;
      $display("FAIL done_wait actual=no_done required=done_within_300 t=%0t", $time);
    end
    check("busy_end", 32'(status_busy), 32'h0);
    check("ack_err_end", 32'(status_ack_err), 32'(m_err));
    check("data_ready_end", 32'(status_data_ready), 32'(m_drdy));
    check("rd_data_end", rd_data, m_rd);
    check("cmds_outstanding", 32'(exp_q.size()), 32'h0);
`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
    check("timeout_end", 32'(timeout), 32'h0);
`endif
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hs_reached", 32'(hs_count >= target), 32'h1);
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    reset_n   = 1'b0;
    cmd_word  = 32'h0;
    wr_word   = 32'h0;
    cmd_valid = 1'b0;
    foreach (rx_bytes[i]) rx_bytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(byte_cmd_valid), 32'h0);
    check("rst_busy", 32'(status_busy), 32'h0);
    check("rst_done", 32'(status_done), 32'h0);
    check("rst_ack_err", 32'(status_ack_err), 32'h0);
    check("rst_drdy", 32'(status_data_ready), 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    reset_n = 1'b1;

    // Write two bytes, all ACK
    start_txn(32'h0000_0150, 32'h0000_BEEF);
    finish_txn();
    check("wr_hs_count", 32'(hs_count), 32'd5);
    check("wr_start", 32'(act_cmd[0]), 32'(C_START));
    check("wr_addr", 32'(act_tx[1]), 32'h0000_00A0);
    check("wr_b0", 32'(act_tx[2]), 32'h0000_00EF);
    check("wr_b1", 32'(act_tx[3]), 32'h0000_00BE);
    check("wr_stop", 32'(act_cmd[4]), 32'(C_STOP));
    check("wr_done", 32'(status_done), 32'h1);

    // Read four bytes, back-to-back with the previous one
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33; rx_bytes[3] = 8'h44;
    start_txn(32'h0000_03D0, 32'h0);
    finish_txn();
    check("rd_literal", rd_data, 32'h4433_2211);
    check("rd_nack_3rd", 32'(act_nack[4]), 32'h0);
    check("rd_nack_4th", 32'(act_nack[5]), 32'h1);
    check("rd_drdy", 32'(status_data_ready), 32'h1);

    // Address NACK
    ack_mask = 8'hFD;
    start_txn(32'h0000_0150, 32'h0000_BEEF);
    finish_txn();
    check("anack_hs_count", 32'(hs_count), 32'd3);
    check("anack_stop", 32'(act_cmd[2]), 32'(C_STOP));
    check("anack_ack_err", 32'(status_ack_err), 32'h1);
    ack_mask = 8'hFF;

    // Backpressure on START plus an ignored command pulse while busy
    stall     = 5;
    eng_delay = 2;
    start_txn(32'h0000_0350, 32'hDEAD_BEEF);
    cmd_word  = 32'h0000_02FF;
    wr_word   = 32'h1234_5678;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    finish_txn();
    check("bp_hs_count", 32'(hs_count), 32'd7);
    eng_delay = 1;

    // NACK on the second write byte of four
    ack_mask = 8'hF7;
    start_txn(32'h0000_0350, 32'hCAFE_F00D);
    finish_txn();
    check("dnack_hs_count", 32'(hs_count), 32'd5);
    ack_mask = 8'hFF;

    // Two-byte read: upper bytes of rd_data must be zero
    rx_bytes[0] = 8'hAA; rx_bytes[1] = 8'hBB;
    start_txn(32'h0000_01A1, 32'h0);
    finish_txn();
    check("rd2_literal", rd_data, 32'h0000_BBAA);

    // Reset while waiting on the address response of a read
    eng_delay = 4;
    start_txn(32'h0000_03D0, 32'h0);
    wait_hs(2);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(byte_cmd_valid), 32'h0);
    check("mid_rst_busy", 32'(status_busy), 32'h0);
    check("mid_rst_flags", {29'h0, status_done, status_ack_err, status_data_ready}, 32'h0);
    check("mid_rst_rd", rd_data, 32'h0);
    exp_q.delete();
    pend = 0;
    m_rd = 32'h0;
    repeat (3) @(negedge clk);
    reset_n   = 1'b1;
    eng_delay = 1;
    rx_bytes[0] = 8'h55; rx_bytes[1] = 8'h66; rx_bytes[2] = 8'h77; rx_bytes[3] = 8'h88;
    start_txn(32'h0000_03D0, 32'h0);
    finish_txn();
    check("post_rst_rd", rd_data, 32'h8877_6655);

`ifdef I2C_TXN_SEQUENCER_TIMEOUT_EN
    // Engine never answers the address byte
    begin
      int n;
      silent_from = 1;
      exp_q.push_back(bc_t'{C_START, 8'h00, 1'b0});
      exp_q.push_back(bc_t'{C_WRITE, 8'hA0, 1'b0});
      hs_count = 0;
      rd_idx   = 0;
      @(posedge clk);
      #1;
      cmd_word  = 32'h0000_0150;
      wr_word   = 32'h0;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_hs(2);
      n = 1;
      while (!status_done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("to_latency", 32'(n), 32'd18);
      check("to_ack_err", 32'(status_ack_err), 32'h1);
      check("to_flag", 32'(timeout), 32'h1);
      check("to_busy", 32'(status_busy), 32'h0);
      check("to_drdy", 32'(status_data_ready), 32'h0);
      check("to_no_stop", 32'(hs_count), 32'd2);
      silent_from = 99;
      start_txn(32'h0000_0150, 32'h0000_BEEF);
      finish_txn();
    end
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
